bidir_bus_delay: RTL and testbench

//  Clocked, multi-bit successor to the strength-based bidirectional delay model.

---
 rtl/bidir_bus_delay.sv | 164 ++++++++++++++++
 tb/tb_bidir_bus_delay.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_bus_delay.sv
// bidir_bus_delay
//   Clocked half-duplex bridge between two tri-state bus agents (side A and
//   side B). Each direction has a fixed DELAY-stage {valid,data} pipeline.
//   An ownership FSM decides which side may push data. It also enforces a
//   TURNAROUND idle gap between owners, and it flags contention instead of
//   resolving it.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   a_oe, a_do     side A drive enable / drive data
//   a_drv, a_q     delayed B data toward side A (valid / data)
//   b_oe, b_do     side B drive enable / drive data
//   b_drv, b_q     delayed A data toward side B (valid / data)
//   dir            0 IDLE, 1 A2B, 2 B2A, 3 TURN or CONFLICT
//   conflict       sticky contention flag, cleared only by reset
//   turn_err       high while any oe is asserted during TURN

module bidir_bus_delay #(
  parameter int WIDTH      = 8,
  parameter int DELAY      = 4,
  parameter int TURNAROUND = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_oe,
  input  logic [WIDTH-1:0] a_do,
  output logic             a_drv,
  output logic [WIDTH-1:0] a_q,
  input  logic             b_oe,
  input  logic [WIDTH-1:0] b_do,
  output logic             b_drv,
  output logic [WIDTH-1:0] b_q,
  output logic [1:0]       dir,
  output logic             conflict,
  output logic             turn_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A2B      = 3'd1,
    B2A      = 3'd2,
    TURN     = 3'd3,
    CONFLICT = 3'd4
  } state_e;

  localparam int CW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CW-1:0] TURN_LOAD = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  state_e           state_q;
  logic [CW-1:0]    turnCnt_q;
  logic             conflict_q;

  logic [DELAY-1:0] pipeAValid_q;
  logic [WIDTH-1:0] pipeAData_q [DELAY];
  logic [DELAY-1:0] pipeBValid_q;
  logic [WIDTH-1:0] pipeBData_q [DELAY];

  logic             pushA;
  logic             pushB;

  // A side may push while it owns the bus. It may also push on the IDLE edge
  // that grants it ownership, so the first beat of a burst is not lost.
  assign pushA = a_oe && ((state_q == A2B) || ((state_q == IDLE) && !b_oe));
  assign pushB = b_oe && ((state_q == B2A) || ((state_q == IDLE) && !a_oe));

  // Ownership FSM. When an owner releases (or contention clears), the FSM
  // goes through TURN for TURNAROUND cycles. With no gap configured, it
  // returns straight to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      turnCnt_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_oe && b_oe) begin
            state_q    <= CONFLICT;
            conflict_q <= 1'b1;
          end else if (a_oe) begin
            state_q <= A2B;
          end else if (b_oe) begin
            state_q <= B2A;
          end
        end
        A2B, B2A: begin
          if ((state_q == A2B) ? b_oe : a_oe) begin
            state_q    <= CONFLICT;
            conflict_q <= 1'b1;
          end else if (!((state_q == A2B) ? a_oe : b_oe)) begin
            if (TURNAROUND == 0) begin
              state_q <= IDLE;
            end else begin
              state_q   <= TURN;
              turnCnt_q <= TURN_LOAD;
            end
          end
        end
        TURN: begin
          if (turnCnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            turnCnt_q <= turnCnt_q - CW'(1);
          end
        end
        CONFLICT: begin
          if (!a_oe && !b_oe) begin
            if (TURNAROUND == 0) begin
              state_q <= IDLE;
            end else begin
              state_q   <= TURN;
              turnCnt_q <= TURN_LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Both pipelines shift every cycle whatever the FSM state. This lets an
  // old direction drain while the new one fills. Data is forced to zero on
  // invalid stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipeAValid_q <= '0;
      pipeBValid_q <= '0;
      for (int i = 0; i < DELAY; i++) begin
        pipeAData_q[i] <= '0;
        pipeBData_q[i] <= '0;
      end
    end else begin
      pipeAValid_q[0] <= pushA;
      pipeAData_q[0]  <= pushA ? a_do : '0;
      pipeBValid_q[0] <= pushB;
      pipeBData_q[0]  <= pushB ? b_do : '0;
      for (int i = 1; i < DELAY; i++) begin
        pipeAValid_q[i] <= pipeAValid_q[i-1];
        pipeAData_q[i]  <= pipeAData_q[i-1];
        pipeBValid_q[i] <= pipeBValid_q[i-1];
        pipeBData_q[i]  <= pipeBData_q[i-1];
      end
    end
  end

  assign b_drv = pipeAValid_q[DELAY-1];
  assign b_q   = pipeAData_q[DELAY-1];
  assign a_drv = pipeBValid_q[DELAY-1];
  assign a_q   = pipeBData_q[DELAY-1];

  always_comb begin
    dir = 2'd3;
    case (state_q)
      IDLE:    dir = 2'd0;
      A2B:     dir = 2'd1;
      B2A:     dir = 2'd2;
      default: dir = 2'd3;
    endcase
  end

  assign conflict = conflict_q;
  assign turn_err = (state_q == TURN) && (a_oe || b_oe);

endmodule

// File: tb/tb_bidir_bus_delay.sv
// tb_bidir_bus_delay
//   Directed bench for bidir_bus_delay. dut0 uses the defaults (8/4/2) and is
//   driven from a vector table plus a mid-burst reset sequence. dut1 uses
//   TURNAROUND=0 and exercises an immediate direction swap. dut2 uses
//   DELAY=1 and WIDTH=1 and checks single-cycle latency.

module tb_bidir_bus_delay;

  logic clk;
  logic rstN;

  logic       aOe0, bOe0, aDrv0, bDrv0, conflict0, turnErr0;
  logic [7:0] aDo0, bDo0, aQ0, bQ0;
  logic [1:0] dir0;

  logic       aOe1, bOe1, aDrv1, bDrv1, conflict1, turnErr1;
  logic [7:0] aDo1, bDo1, aQ1, bQ1;
  logic [1:0] dir1;

  logic       aOe2, bOe2, aDrv2, bDrv2, conflict2, turnErr2;
  logic [0:0] aDo2, bDo2, aQ2, bQ2;
  logic [1:0] dir2;

  int checks   = 0;
  int failures = 0;

  bidir_bus_delay #(.WIDTH(8), .DELAY(4), .TURNAROUND(2)) dut0 (
    .clk(clk), .rst_n(rstN),
    .a_oe(aOe0), .a_do(aDo0), .a_drv(aDrv0), .a_q(aQ0),
    .b_oe(bOe0), .b_do(bDo0), .b_drv(bDrv0), .b_q(bQ0),
    .dir(dir0), .conflict(conflict0), .turn_err(turnErr0)
  );

  bidir_bus_delay #(.WIDTH(8), .DELAY(4), .TURNAROUND(0)) dut1 (
    .clk(clk), .rst_n(rstN),
    .a_oe(aOe1), .a_do(aDo1), .a_drv(aDrv1), .a_q(aQ1),
    .b_oe(bOe1), .b_do(bDo1), .b_drv(bDrv1), .b_q(bQ1),
    .dir(dir1), .conflict(conflict1), .turn_err(turnErr1)
  );

  bidir_bus_delay #(.WIDTH(1), .DELAY(1), .TURNAROUND(2)) dut2 (
    .clk(clk), .rst_n(rstN),
    .a_oe(aOe2), .a_do(aDo2), .a_drv(aDrv2), .a_q(aQ2),
    .b_oe(bOe2), .b_do(bDo2), .b_drv(bDrv2), .b_q(bQ2),
    .dir(dir2), .conflict(conflict2), .turn_err(turnErr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       aOe;
    logic [7:0] aDo;
    logic       bOe;
    logic [7:0] bDo;
    logic       expBDrv;
    logic [7:0] expBQ;
    logic       expADrv;
    logic [7:0] expAQ;
    logic [1:0] expDir;
    logic       expConflict;
    logic       expTurnErr;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t mkVec(logic aOe, logic [7:0] aDo, logic bOe, logic [7:0] bDo,
                                 logic bDrv, logic [7:0] bQ, logic aDrv, logic [7:0] aQ,
                                 logic [1:0] dir, logic conf, logic terr);
    vec_t v;
    v.aOe = aOe; v.aDo = aDo; v.bOe = bOe; v.bDo = bDo;
    v.expBDrv = bDrv; v.expBQ = bQ; v.expADrv = aDrv; v.expAQ = aQ;
    v.expDir = dir; v.expConflict = conf; v.expTurnErr = terr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge. Outputs are sampled on
  // the following falling edge, before the next rising edge samples the inputs.
  task automatic applyStimulus(input int which, input logic aOe, input logic [7:0] aDo,
                               input logic bOe, input logic [7:0] bDo);
    @(posedge clk);
    #2;
    case (which)
      0: begin aOe0 = aOe; aDo0 = aDo; bOe0 = bOe; bDo0 = bDo; end
      1: begin aOe1 = aOe; aDo1 = aDo; bOe1 = bOe; bDo1 = bDo; end
      default: begin aOe2 = aOe; aDo2 = aDo[0]; bOe2 = bOe; bDo2 = bDo[0]; end
    endcase
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic prevBit;
    logic curBit;

    // Rows 1-13: a three-beat A burst, then B requests right after the release.
    // Rows 14-23: contention in A2B, the CONFLICT->TURN exit, and a turn_err
    // case whose data must not be forwarded.
    vecs[0]  = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd0, 0, 0);
    vecs[1]  = mkVec(1, 8'h11, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd0, 0, 0);
    vecs[2]  = mkVec(1, 8'h22, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd1, 0, 0);
    vecs[3]  = mkVec(1, 8'h33, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd1, 0, 0);
    vecs[4]  = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd1, 0, 0);
    vecs[5]  = mkVec(0, 8'h00, 1, 8'hA5, 1, 8'h11, 0, 8'h00, 2'd3, 0, 1);
    vecs[6]  = mkVec(0, 8'h00, 1, 8'hA6, 1, 8'h22, 0, 8'h00, 2'd3, 0, 1);
    vecs[7]  = mkVec(0, 8'h00, 1, 8'hB7, 1, 8'h33, 0, 8'h00, 2'd0, 0, 0);
    vecs[8]  = mkVec(0, 8'h00, 1, 8'hB8, 0, 8'h00, 0, 8'h00, 2'd2, 0, 0);
    vecs[9]  = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd2, 0, 0);
    vecs[10] = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd3, 0, 0);
    vecs[11] = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'hB7, 2'd3, 0, 0);
    vecs[12] = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'hB8, 2'd0, 0, 0);
    vecs[13] = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd0, 0, 0);
    vecs[14] = mkVec(1, 8'h44, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd0, 0, 0);
    vecs[15] = mkVec(1, 8'h55, 1, 8'h66, 0, 8'h00, 0, 8'h00, 2'd1, 0, 0);
    vecs[16] = mkVec(1, 8'h77, 1, 8'h88, 0, 8'h00, 0, 8'h00, 2'd3, 1, 0);
    vecs[17] = mkVec(0, 8'h00, 1, 8'h88, 0, 8'h00, 0, 8'h00, 2'd3, 1, 0);
    vecs[18] = mkVec(0, 8'h00, 0, 8'h00, 1, 8'h44, 0, 8'h00, 2'd3, 1, 0);
    vecs[19] = mkVec(1, 8'h99, 0, 8'h00, 1, 8'h55, 0, 8'h00, 2'd3, 1, 1);
    vecs[20] = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd3, 1, 0);
    vecs[21] = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd0, 1, 0);
    vecs[22] = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd0, 1, 0);
    vecs[23] = mkVec(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2'd0, 1, 0);

    rstN = 1'b0;
    aOe0 = 0; aDo0 = '0; bOe0 = 0; bDo0 = '0;
    aOe1 = 0; aDo1 = '0; bOe1 = 0; bDo1 = '0;
    aOe2 = 0; aDo2 = '0; bOe2 = 0; bDo2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_b_drv", 32'(bDrv0), 32'd0);
    checkOutput("reset_a_drv", 32'(aDrv0), 32'd0);
    checkOutput("reset_b_q", 32'(bQ0), 32'd0);
    checkOutput("reset_a_q", 32'(aQ0), 32'd0);
    checkOutput("reset_dir", 32'(dir0), 32'd0);
    checkOutput("reset_conflict", 32'(conflict0), 32'd0);
    checkOutput("reset_turn_err", 32'(turnErr0), 32'd0);
    @(posedge clk);
    #2 rstN = 1'b1;

    // T1..T3 table on dut0
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(0, vecs[i].aOe, vecs[i].aDo, vecs[i].bOe, vecs[i].bDo);
      checkOutput($sformatf("row%0d_b_drv", i), 32'(bDrv0), 32'(vecs[i].expBDrv));
      checkOutput($sformatf("row%0d_b_q", i), 32'(bQ0), 32'(vecs[i].expBQ));
      checkOutput($sformatf("row%0d_a_drv", i), 32'(aDrv0), 32'(vecs[i].expADrv));
      checkOutput($sformatf("row%0d_a_q", i), 32'(aQ0), 32'(vecs[i].expAQ));
      checkOutput($sformatf("row%0d_dir", i), 32'(dir0), 32'(vecs[i].expDir));
      checkOutput($sformatf("row%0d_conflict", i), 32'(conflict0), 32'(vecs[i].expConflict));
      checkOutput($sformatf("row%0d_turn_err", i), 32'(turnErr0), 32'(vecs[i].expTurnErr));
    end

    // T5: reset mid-burst. Five beats are pushed. After the fifth edge the
    // second beat (0x34) is on b_q, and reset must clear it without a clock edge.
    applyStimulus(0, 1, 8'h12, 0, 8'h00);
    applyStimulus(0, 1, 8'h34, 0, 8'h00);
    applyStimulus(0, 1, 8'h56, 0, 8'h00);
    applyStimulus(0, 1, 8'h78, 0, 8'h00);
    applyStimulus(0, 1, 8'h9A, 0, 8'h00);
    @(posedge clk);
    #2;
    checkOutput("t5_pre_b_drv", 32'(bDrv0), 32'd1);
    checkOutput("t5_pre_b_q", 32'(bQ0), 32'h34);
    aOe0 = 0; aDo0 = '0;
    rstN = 1'b0;
    #1;
    checkOutput("t5_async_b_drv", 32'(bDrv0), 32'd0);
    checkOutput("t5_async_b_q", 32'(bQ0), 32'd0);
    checkOutput("t5_async_dir", 32'(dir0), 32'd0);
    checkOutput("t5_async_conflict", 32'(conflict0), 32'd0);
    @(posedge clk);
    #2 rstN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 8'h00);
      checkOutput($sformatf("t5_stale%0d_b_drv", i), 32'(bDrv0), 32'd0);
      checkOutput($sformatf("t5_stale%0d_b_q", i), 32'(bQ0), 32'd0);
    end

    // T4: TURNAROUND=0. dir goes 1 -> 0 -> 2 and B's first beat is forwarded.
    applyStimulus(1, 1, 8'h21, 0, 8'h00);
    checkOutput("t4_r0_dir", 32'(dir1), 32'd0);
    applyStimulus(1, 0, 8'h00, 0, 8'h00);
    checkOutput("t4_r1_dir", 32'(dir1), 32'd1);
    applyStimulus(1, 0, 8'h00, 1, 8'h31);
    checkOutput("t4_r2_dir", 32'(dir1), 32'd0);
    checkOutput("t4_r2_turn_err", 32'(turnErr1), 32'd0);
    applyStimulus(1, 0, 8'h00, 0, 8'h00);
    checkOutput("t4_r3_dir", 32'(dir1), 32'd2);
    applyStimulus(1, 0, 8'h00, 0, 8'h00);
    checkOutput("t4_r4_dir", 32'(dir1), 32'd0);
    checkOutput("t4_r4_b_drv", 32'(bDrv1), 32'd1);
    checkOutput("t4_r4_b_q", 32'(bQ1), 32'h21);
    applyStimulus(1, 0, 8'h00, 0, 8'h00);
    checkOutput("t4_r5_a_drv", 32'(aDrv1), 32'd0);
    checkOutput("t4_r5_b_drv", 32'(bDrv1), 32'd0);
    applyStimulus(1, 0, 8'h00, 0, 8'h00);
    checkOutput("t4_r6_a_drv", 32'(aDrv1), 32'd1);
    checkOutput("t4_r6_a_q", 32'(aQ1), 32'h31);
    checkOutput("t4_r6_conflict", 32'(conflict1), 32'd0);

    // T6: DELAY=1, WIDTH=1. b_q follows a_do one edge later.
    prevBit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      curBit = ~k[0];
      applyStimulus(2, 1, {7'd0, curBit}, 0, 8'h00);
      if (k == 0) begin
        checkOutput("t6_r0_b_drv", 32'(bDrv2), 32'd0);
        checkOutput("t6_r0_dir", 32'(dir2), 32'd0);
      end else begin
        checkOutput($sformatf("t6_r%0d_b_drv", k), 32'(bDrv2), 32'd1);
        checkOutput($sformatf("t6_r%0d_b_q", k), 32'(bQ2), 32'(prevBit));
      end
      prevBit = curBit;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
